// File: rtl/lcd_scan_pkg.sv
// Shared types and constants for the vmem_lcd_scan LCD streamer: FSM states,
// init/header command ROMs and the 3-bit to RGB565 colour expansion.
package lcd_scan_pkg;

  localparam int LCD_W    = 240;
  localparam int INIT_LEN = 6;
  localparam int HDR_LEN  = 11;

  typedef enum logic [2:0] {
    ST_HWRST = 3'd0,
    ST_RWAIT = 3'd1,
    ST_INIT  = 3'd2,
    ST_HDR   = 3'd3,
    ST_PIX   = 3'd4
  } state_e;

  typedef struct packed {
    logic       is_cmd;
    logic       is_delay;
    logic [7:0] data;
  } rom_entry_t;

  // Entry 1 is the SLPOUT settle delay; it carries no byte.
  function automatic rom_entry_t init_rom(input logic [3:0] idx);
    rom_entry_t e;
    case (idx)
      4'd0:    e = '{is_cmd: 1'b1, is_delay: 1'b0, data: 8'h11};
      4'd1:    e = '{is_cmd: 1'b0, is_delay: 1'b1, data: 8'h00};
      4'd2:    e = '{is_cmd: 1'b1, is_delay: 1'b0, data: 8'h3A};
      4'd3:    e = '{is_cmd: 1'b0, is_delay: 1'b0, data: 8'h55};
      4'd4:    e = '{is_cmd: 1'b1, is_delay: 1'b0, data: 8'h21};
      4'd5:    e = '{is_cmd: 1'b1, is_delay: 1'b0, data: 8'h29};
      default: e = '{is_cmd: 1'b0, is_delay: 1'b0, data: 8'h00};
    endcase
    return e;
  endfunction

  function automatic rom_entry_t hdr_rom(input logic [3:0] idx);
    rom_entry_t e;
    case (idx)
      4'd0:                   e = '{is_cmd: 1'b1, is_delay: 1'b0, data: 8'h2A};
      4'd1, 4'd2, 4'd3:       e = '{is_cmd: 1'b0, is_delay: 1'b0, data: 8'h00};
      4'd4:                   e = '{is_cmd: 1'b0, is_delay: 1'b0, data: 8'hEF};
      4'd5:                   e = '{is_cmd: 1'b1, is_delay: 1'b0, data: 8'h2B};
      4'd6, 4'd7, 4'd8:       e = '{is_cmd: 1'b0, is_delay: 1'b0, data: 8'h00};
      4'd9:                   e = '{is_cmd: 1'b0, is_delay: 1'b0, data: 8'hEF};
      4'd10:                  e = '{is_cmd: 1'b1, is_delay: 1'b0, data: 8'h2C};
      default:                e = '{is_cmd: 1'b0, is_delay: 1'b0, data: 8'h00};
    endcase
    return e;
  endfunction

  function automatic logic [15:0] rgb565(input logic [2:0] c);
    return {{5{c[2]}}, {6{c[1]}}, {5{c[0]}}};
  endfunction

endpackage

// File: rtl/lcd_spi_tx.sv
// Write-only SPI mode 3 byte shifter: MSB first, SCLK idles high, each half
// period lasts SCLK_DIV clocks. o_done marks the final cycle so a new byte can follow with no gap.
module lcd_spi_tx #(
  parameter int SCLK_DIV = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       i_start,
  input  logic [7:0] i_byte,
  input  logic       i_dc,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_sclk,
  output logic       o_sda,
  output logic       o_dc
);

  localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

  logic [7:0]    r_shift;
  logic [2:0]    r_bit;
  logic [DW-1:0] r_div;
  logic          r_busy;
  logic          r_sclk;
  logic          r_sda;
  logic          r_dc;
  logic          w_half_end;

  assign w_half_end = (r_div == DW'(SCLK_DIV - 1));
  assign o_done     = r_busy & r_sclk & w_half_end & (r_bit == 3'd7);
  assign o_busy     = r_busy;
  assign o_sclk     = r_sclk;
  assign o_sda      = r_sda;
  assign o_dc       = r_dc;

  // Data only moves on the edge that drops SCLK, so it is stable while SCLK is high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_shift <= 8'h00;
      r_bit   <= 3'd0;
      r_div   <= '0;
      r_busy  <= 1'b0;
      r_sclk  <= 1'b1;
      r_sda   <= 1'b0;
      r_dc    <= 1'b0;
    end else if (i_start) begin
      r_shift <= i_byte;
      r_bit   <= 3'd0;
      r_div   <= '0;
      r_busy  <= 1'b1;
      r_sclk  <= 1'b0;
      r_sda   <= i_byte[7];
      r_dc    <= i_dc;
    end else if (r_busy) begin
      if (w_half_end) begin
        r_div <= '0;
        if (!r_sclk) begin
          r_sclk <= 1'b1;
        end else if (r_bit == 3'd7) begin
          r_busy <= 1'b0;
        end else begin
          r_sclk  <= 1'b0;
          r_bit   <= r_bit + 3'd1;
          r_shift <= {r_shift[6:0], 1'b0};
          r_sda   <= r_shift[6];
        end
      end else begin
        r_div <= r_div + DW'(1);
      end
    end
  end

endmodule

// File: rtl/vmem_lcd_scan.sv
// Scans video memory and streams RGB565 pixels to an ST7789-class SPI LCD,
// after panel reset and init. Optional macro LCD_SCAN_FRAMECNT_EN adds frame_cnt_o.
module vmem_lcd_scan
  import lcd_scan_pkg::*;
#(
  parameter int VMEM_ADDRW   = 16,
  parameter int VMEM_ENTRIES = 57600,
  parameter int SCLK_DIV     = 2,
  parameter int RST_CYCLES   = 1000000,
  parameter int SLP_CYCLES   = 6000000
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  output logic [VMEM_ADDRW-1:0] raddr_o,
  input  logic [2:0]            rdata_i,
  output logic                  lcd_sclk_o,
  output logic                  lcd_sda_o,
  output logic                  lcd_dc_o,
  output logic                  lcd_cs_o,
  output logic                  lcd_res_o,
  output logic                  frame_done_o
`ifdef LCD_SCAN_FRAMECNT_EN
  ,
  output logic [31:0]           frame_cnt_o
`endif
);

  localparam logic [VMEM_ADDRW-1:0] LAST_ADDR = VMEM_ADDRW'(VMEM_ENTRIES - 1);
  localparam logic [31:0]           RST_LAST  = 32'(RST_CYCLES - 1);
  localparam logic [31:0]           SLP_LAST  = 32'(SLP_CYCLES - 1);
  localparam logic [3:0]            INIT_LAST = 4'(INIT_LEN - 1);
  localparam logic [3:0]            HDR_LAST  = 4'(HDR_LEN - 1);

  state_e                r_state, w_state_nxt;
  logic [31:0]           r_cnt, w_cnt_nxt;
  logic [3:0]            r_idx, w_idx_nxt;
  logic [VMEM_ADDRW-1:0] r_pix_n, w_pix_n_nxt;
  logic [VMEM_ADDRW-1:0] r_raddr, w_raddr_nxt;
  logic                  r_lo_phase, w_lo_phase_nxt;
  logic                  r_last, w_last_nxt;
  logic [7:0]            r_lo_byte, w_lo_byte_nxt;
  logic                  r_cs, w_cs_nxt;
  logic                  r_res, w_res_nxt;
  logic                  r_frame_done, w_fdone_nxt;
  logic [2:0]            r_pipe;
  logic [2:0]            r_pref;
  logic                  w_fetch;
  logic                  w_start;
  logic [7:0]            w_byte;
  logic                  w_dc;
  logic                  w_tx_busy;
  logic                  w_tx_done;
  logic                  w_tx_ready;
  rom_entry_t            w_init_ent;
  rom_entry_t            w_hdr_ent;
  logic [15:0]           w_rgb;

  assign w_init_ent = init_rom(r_idx);
  assign w_hdr_ent  = hdr_rom(r_idx);
  assign w_rgb      = rgb565(r_pref);
  assign w_tx_ready = ~w_tx_busy | w_tx_done;

  lcd_spi_tx #(
    .SCLK_DIV (SCLK_DIV)
  ) u_tx (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_start (w_start),
    .i_byte  (w_byte),
    .i_dc    (w_dc),
    .o_busy  (w_tx_busy),
    .o_done  (w_tx_done),
    .o_sclk  (lcd_sclk_o),
    .o_sda   (lcd_sda_o),
    .o_dc    (lcd_dc_o)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_HWRST;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, byte selection and fetch control; a new byte is always queued on the shifter's last cycle.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_idx_nxt      = r_idx;
    w_pix_n_nxt    = r_pix_n;
    w_raddr_nxt    = r_raddr;
    w_lo_phase_nxt = r_lo_phase;
    w_last_nxt     = r_last;
    w_lo_byte_nxt  = r_lo_byte;
    w_cs_nxt       = r_cs;
    w_res_nxt      = r_res;
    w_fdone_nxt    = 1'b0;
    w_fetch        = 1'b0;
    w_start        = 1'b0;
    w_byte         = 8'h00;
    w_dc           = 1'b0;
    case (r_state)
      ST_HWRST: begin
        w_res_nxt = 1'b0;
        if (r_cnt == RST_LAST) begin
          w_cnt_nxt   = 32'd0;
          w_res_nxt   = 1'b1;
          w_state_nxt = ST_RWAIT;
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end
      ST_RWAIT: begin
        if (r_cnt == RST_LAST) begin
          w_cnt_nxt   = 32'd0;
          w_idx_nxt   = 4'd0;
          w_state_nxt = ST_INIT;
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end
      ST_INIT: begin
        if (w_init_ent.is_delay) begin
          // The sleep-out wait starts only once the SLPOUT byte has fully left the shifter.
          if (w_tx_busy) begin
            w_cnt_nxt = r_cnt;
          end else if (r_cnt == SLP_LAST) begin
            w_cnt_nxt = 32'd0;
            w_idx_nxt = r_idx + 4'd1;
          end else begin
            w_cnt_nxt = r_cnt + 32'd1;
          end
        end else if (w_tx_ready) begin
          w_start  = 1'b1;
          w_byte   = w_init_ent.data;
          w_dc     = ~w_init_ent.is_cmd;
          w_cs_nxt = 1'b0;
          if (r_idx == INIT_LAST) begin
            w_idx_nxt   = 4'd0;
            w_state_nxt = ST_HDR;
          end else begin
            w_idx_nxt = r_idx + 4'd1;
          end
        end else begin
          w_idx_nxt = r_idx;
        end
      end
      ST_HDR: begin
        if (w_tx_ready && !w_hdr_ent.is_delay) begin
          w_start = 1'b1;
          w_byte  = w_hdr_ent.data;
          w_dc    = ~w_hdr_ent.is_cmd;
          if (r_idx == HDR_LAST) begin
            w_idx_nxt      = 4'd0;
            w_state_nxt    = ST_PIX;
            w_lo_phase_nxt = 1'b0;
            w_fetch        = 1'b1;
          end else begin
            w_idx_nxt = r_idx + 4'd1;
          end
        end else begin
          w_idx_nxt = r_idx;
        end
      end
      ST_PIX: begin
        if (!w_tx_ready) begin
          w_idx_nxt = r_idx;
        end else if (r_last) begin
          // r_idx is 0 here, so the header ROM yields the column-address command.
          w_start     = 1'b1;
          w_byte      = w_hdr_ent.data;
          w_dc        = ~w_hdr_ent.is_cmd;
          w_idx_nxt   = 4'd1;
          w_state_nxt = ST_HDR;
          w_fdone_nxt = 1'b1;
          w_raddr_nxt = '0;
          w_last_nxt  = 1'b0;
        end else if (!r_lo_phase) begin
          w_start        = 1'b1;
          w_byte         = w_rgb[15:8];
          w_dc           = 1'b1;
          w_lo_byte_nxt  = w_rgb[7:0];
          w_lo_phase_nxt = 1'b1;
          if (r_pix_n != LAST_ADDR) begin
            w_raddr_nxt = r_pix_n + VMEM_ADDRW'(1);
            w_fetch     = 1'b1;
          end else begin
            w_raddr_nxt = r_raddr;
          end
        end else begin
          w_start        = 1'b1;
          w_byte         = r_lo_byte;
          w_dc           = 1'b1;
          w_lo_phase_nxt = 1'b0;
          if (r_pix_n == LAST_ADDR) begin
            w_last_nxt  = 1'b1;
            w_pix_n_nxt = '0;
          end else begin
            w_pix_n_nxt = r_pix_n + VMEM_ADDRW'(1);
          end
        end
      end
      default: begin
        w_state_nxt = ST_HWRST;
      end
    endcase
  end

  // Datapath registers; rdata_i is captured three edges after its address is driven.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt        <= 32'd0;
      r_idx        <= 4'd0;
      r_pix_n      <= '0;
      r_raddr      <= '0;
      r_lo_phase   <= 1'b0;
      r_last       <= 1'b0;
      r_lo_byte    <= 8'h00;
      r_cs         <= 1'b1;
      r_res        <= 1'b0;
      r_frame_done <= 1'b0;
      r_pipe       <= 3'b000;
      r_pref       <= 3'b000;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_idx        <= w_idx_nxt;
      r_pix_n      <= w_pix_n_nxt;
      r_raddr      <= w_raddr_nxt;
      r_lo_phase   <= w_lo_phase_nxt;
      r_last       <= w_last_nxt;
      r_lo_byte    <= w_lo_byte_nxt;
      r_cs         <= w_cs_nxt;
      r_res        <= w_res_nxt;
      r_frame_done <= w_fdone_nxt;
      r_pipe       <= {r_pipe[1:0], w_fetch};
      if (r_pipe[2]) begin
        r_pref <= rdata_i;
      end
    end
  end

  assign raddr_o      = r_raddr;
  assign lcd_cs_o     = r_cs;
  assign lcd_res_o    = r_res;
  assign frame_done_o = r_frame_done;

`ifdef LCD_SCAN_FRAMECNT_EN
  logic [31:0] r_frame_cnt;

  // Frame counter, stepping on the same edge that raises frame_done_o.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_frame_cnt <= 32'd0;
    end else if (w_fdone_nxt) begin
      r_frame_cnt <= r_frame_cnt + 32'd1;
    end
  end

  assign frame_cnt_o = r_frame_cnt;
`endif

endmodule

// File: tb/tb_vmem_lcd_scan.sv
// Self-checking bench for vmem_lcd_scan: decodes the SPI byte stream and compares it
// with a reference stream built from the command list and colour rules.
module tb_vmem_lcd_scan;

  localparam int NF = 6;

  typedef struct packed {
    logic [3:0][2:0] c;
    logic [7:0][7:0] b;
  } fvec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] raddr, raddr3;
  logic [2:0]  rdata, rdata3, d1, d13;
  logic        sclk, sda, dc, cs, res, fdone;
  logic        sclk3, sda3, dc3, cs3, res3, fdone3;
`ifdef LCD_SCAN_FRAMECNT_EN
  logic [31:0] fcnt, fcnt3;
`endif

  logic [2:0]  mem [0:3];
  fvec_t       vecs [NF];
  logic [8:0]  byteq [$];
  logic [8:0]  exp_q [$];
  int          frames_seen;
  int          n_chk = 0;
  int          n_pass = 0;
  int          armed_ever = 0;

  always #5 clk = ~clk;

  // Two-cycle-latency vmem models.
  always @(posedge clk) begin
    d1    <= mem[raddr[1:0]];
    rdata <= d1;
    d13    <= mem[raddr3[1:0]];
    rdata3 <= d13;
  end

  vmem_lcd_scan #(
    .VMEM_ADDRW(16), .VMEM_ENTRIES(4), .SCLK_DIV(1), .RST_CYCLES(4), .SLP_CYCLES(8)
  ) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .raddr_o(raddr), .rdata_i(rdata),
    .lcd_sclk_o(sclk), .lcd_sda_o(sda), .lcd_dc_o(dc), .lcd_cs_o(cs),
    .lcd_res_o(res), .frame_done_o(fdone)
`ifdef LCD_SCAN_FRAMECNT_EN
    , .frame_cnt_o(fcnt)
`endif
  );

  vmem_lcd_scan #(
    .VMEM_ADDRW(16), .VMEM_ENTRIES(4), .SCLK_DIV(3), .RST_CYCLES(4), .SLP_CYCLES(8)
  ) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .raddr_o(raddr3), .rdata_i(rdata3),
    .lcd_sclk_o(sclk3), .lcd_sda_o(sda3), .lcd_dc_o(dc3), .lcd_cs_o(cs3),
    .lcd_res_o(res3), .frame_done_o(fdone3)
`ifdef LCD_SCAN_FRAMECNT_EN
    , .frame_cnt_o(fcnt3)
`endif
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int ref_rgb(input logic [2:0] c);
    int r, g, b;
    r = c[2] ? 31 : 0;
    g = c[1] ? 63 : 0;
    b = c[0] ? 31 : 0;
    return r * 2048 + g * 32 + b;
  endfunction

  task automatic load_mem(input int k);
    for (int p = 0; p < 4; p++) mem[p] = vecs[k].c[p];
  endtask

  // Decoder for the SCLK_DIV=1 instance: bytes, frame_done, raddr order.
  initial begin : mon1
    int bitcnt, prev_sclk, byte_dc, dc_bad, fd_run, cyc, t_last0;
    logic [7:0]  shreg;
    logic [15:0] prev_raddr;
    bool_init: begin
      bitcnt = 0; prev_sclk = 1; fd_run = 0; cyc = 0; t_last0 = 0;
      prev_raddr = 16'd0; dc_bad = 0; byte_dc = 0; shreg = 8'h00;
    end
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n !== 1'b1) begin
        bitcnt = 0; prev_sclk = 1; fd_run = 0; prev_raddr = 16'd0;
        frames_seen = 0;
        byteq.delete();
      end else begin
        if (sclk && !prev_sclk) begin
          if (bitcnt == 0) begin
            byte_dc = dc;
            dc_bad = 0;
            if (byteq.size() == 0) check("cs_low_first_byte", cs, 0);
            if (byteq.size() == 1) check("slp_gap_ok", (cyc - t_last0) >= 10, 1);
          end else if (dc != byte_dc[0]) begin
            dc_bad = 1;
          end
          shreg = {shreg[6:0], sda};
          bitcnt++;
          if (bitcnt == 8) begin
            byteq.push_back({byte_dc[0], shreg});
            check("dc_const_in_byte", dc_bad, 0);
            if (byteq.size() == 1) t_last0 = cyc;
            bitcnt = 0;
          end
        end
        prev_sclk = sclk;
        if (raddr != prev_raddr) begin
          check("raddr_seq", raddr, (prev_raddr + 16'd1) % 16'd4);
          prev_raddr = raddr;
        end
        if (fdone) begin
          fd_run++;
          if (fd_run == 1) begin
            frames_seen++;
            check("bytes_at_frame_done", byteq.size(), 5 + 19 * frames_seen);
`ifdef LCD_SCAN_FRAMECNT_EN
            check("frame_cnt", fcnt, frames_seen);
`endif
            if (frames_seen < NF) load_mem(frames_seen);
          end
        end else begin
          if (fd_run > 0) check("frame_done_width", fd_run, 1);
          fd_run = 0;
        end
      end
    end
  end

  // SCLK phase lengths and data stability for the SCLK_DIV=3 instance, once streaming.
  initial begin : mon3
    int run3, armed3;
    logic prev_sclk3, prev_sda3, prev_dc3;
    logic [15:0] prev_raddr3;
    run3 = 0; armed3 = 0; prev_sclk3 = 1'b1; prev_sda3 = 1'b0; prev_dc3 = 1'b0;
    prev_raddr3 = 16'd0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        run3 = 0; armed3 = 0; prev_sclk3 = 1'b1; prev_raddr3 = 16'd0;
      end else begin
        if (fdone3) begin
          armed3 = 1;
          armed_ever = 1;
        end
        if (sclk3 == prev_sclk3) begin
          run3++;
        end else begin
          if (armed3 != 0) begin
            if (!prev_sclk3) check("sclk3_low_phase", run3, 3);
            else check("sclk3_high_phase", run3, 3);
          end
          run3 = 1;
        end
        if (armed3 != 0 && sclk3 && prev_sclk3)
          check("sda_dc_stable_high", {sda3, dc3}, {prev_sda3, prev_dc3});
        if (raddr3 != prev_raddr3) begin
          check("raddr3_range", raddr3 < 16'd4, 1);
          prev_raddr3 = raddr3;
        end
        prev_sclk3 = sclk3;
        prev_sda3  = sda3;
        prev_dc3   = dc3;
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_raddr"}, raddr, 0);
    check({tag, "_sclk"}, sclk, 1);
    check({tag, "_sda"}, sda, 0);
    check({tag, "_dc"}, dc, 0);
    check({tag, "_cs"}, cs, 1);
    check({tag, "_res"}, res, 0);
    check({tag, "_frame_done"}, fdone, 0);
  endtask

  task automatic check_res_low();
    int n;
    n = 0;
    while (res == 1'b0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("res_low_cycles", n, 4);
  endtask

  task automatic run_and_compare(input int nf);
    int t;
    longint act;
    exp_q = {9'h011, 9'h03A, 9'h155, 9'h021, 9'h029};
    for (int f = 0; f < nf; f++) begin
      exp_q.push_back(9'h02A);
      repeat (3) exp_q.push_back(9'h100);
      exp_q.push_back(9'h1EF);
      exp_q.push_back(9'h02B);
      repeat (3) exp_q.push_back(9'h100);
      exp_q.push_back(9'h1EF);
      exp_q.push_back(9'h02C);
      for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, vecs[f].b[i]});
    end
    exp_q.push_back(9'h02A);
    t = 0;
    while (!(frames_seen >= nf && byteq.size() >= exp_q.size()) && t < 8000) begin
      @(negedge clk);
      t++;
    end
    check("stream_complete_in_time", t < 8000, 1);
    for (int i = 0; i < exp_q.size(); i++) begin
      act = (i < byteq.size()) ? longint'(byteq[i]) : -1;
      check($sformatf("byte[%0d]{dc,data}", i), act, exp_q[i]);
    end
  endtask

  initial begin : main
    int t, rgb;
    vecs[0].c = {3'b111, 3'b001, 3'b010, 3'b100};
    vecs[0].b = {8'hFF, 8'hFF, 8'h1F, 8'h00, 8'hE0, 8'h07, 8'h00, 8'hF8};
    vecs[1].c = {3'b110, 3'b101, 3'b011, 3'b000};
    vecs[1].b = {8'hE0, 8'hFF, 8'h1F, 8'hF8, 8'hFF, 8'h07, 8'h00, 8'h00};
    for (int v = 2; v < NF; v++) begin
      for (int p = 0; p < 4; p++) begin
        vecs[v].c[p] = 3'($urandom_range(0, 7));
        rgb = ref_rgb(vecs[v].c[p]);
        vecs[v].b[2 * p]     = 8'(rgb / 256);
        vecs[v].b[2 * p + 1] = 8'(rgb % 256);
      end
    end
    load_mem(0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    check_res_low();
    run_and_compare(NF);

    // Interrupt the third pixel byte of the next frame.
    t = 0;
    while (frames_seen < NF + 1 && t < 2000) begin @(negedge clk); t++; end
    while (byteq.size() < 5 + 19 * (NF + 1) + 13 && t < 4000) begin @(negedge clk); t++; end
    check("reach_mid_pixel_in_time", t < 4000, 1);
    repeat (5) @(negedge clk);
    check("mid_pixel_dc", dc, 1);
    rst_n = 1'b0;
    #1;
    check_reset_values("midbyte_reset");
    repeat (3) @(negedge clk);
    load_mem(0);
    rst_n = 1'b1;
    check_res_low();
    run_and_compare(2);

    check("sclk_div3_streamed", armed_ever, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
